// File: rtl/uart_receiver_if.sv
// uart_receiver_if: bundles the serial input and the received-byte outputs of
// uart_receiver.
//   uart_rx       - serial line, idle high, asynchronous to the receiver clock
//   byte_data     - last correctly framed byte
//   byte_valid    - one-cycle pulse when byte_data is updated
//   framing_error - one-cycle pulse when the stop bit is sampled low
//   parity_error  - one-cycle pulse on an even-parity failure (0 when parity is off)
// Modports: master = the receiver, slave = line driver / byte consumer.
interface uart_receiver_if;
  logic       uart_rx;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       framing_error;
  logic       parity_error;

  modport master (
    input  uart_rx,
    output byte_data, byte_valid, framing_error, parity_error
  );

  modport slave (
    output uart_rx,
    input  byte_data, byte_valid, framing_error, parity_error
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8-bit asynchronous serial receiver, 1 start bit, 8 data bits
// LSB first, optional even parity bit, 1 stop bit.
// Ports:
//   clk - receiver clock, all state on the rising edge
//   rst - asynchronous active-high reset
//   bus - uart_receiver_if.master (uart_rx in; byte_data, byte_valid,
//         framing_error, parity_error out)
// Parameters: clk_mhz (clock in MHz), baud_rate (bits/s).
// Optional feature: define UART_RECEIVER_PARITY_EN to expect an even-parity bit
// after the data bits; otherwise the frame is 10 bits and parity_error is 0.
//
// state     | meaning
// IDLE      | line idle, waiting for rx_s low
// START     | half-period wait, then confirm start bit (glitch filter)
// DATA      | sample 8 data bits, one per bit period
// PARITY    | sample parity bit (only with parity enabled)
// STOP      | sample stop bit, report byte or error
// WAIT_HIGH | bad stop bit seen, wait for the line to return high
module uart_receiver #(
  parameter int clk_mhz   = 50,
  parameter int baud_rate = 115200
) (
  input logic             clk,
  input logic             rst,
  uart_receiver_if.master bus
);

  localparam int P    = (clk_mhz * 1000000) / baud_rate;
  localparam int HALF = P / 2;
  localparam int CW   = $clog2(P + 1);
  localparam logic [CW-1:0] P_M1    = CW'(P - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    byte_data_r;
  logic          byte_valid_r;
  logic          framing_error_r;
`ifdef UART_RECEIVER_PARITY_EN
  logic          par_bit;
  logic          parity_error_r;
`endif

  // Synchronizer resets to 1 so a reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // cnt is a down-counter; a sample is taken on the cycle it is already 0,
  // so loading N-1 gives a sample exactly N cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      byte_data_r     <= 8'h00;
      byte_valid_r    <= 1'b0;
      framing_error_r <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
      par_bit         <= 1'b0;
      parity_error_r  <= 1'b0;
`endif
    end else begin
      byte_valid_r    <= 1'b0;
      framing_error_r <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
      parity_error_r  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= HALF_M1;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            state <= IDLE;
          end else begin
            state   <= DATA;
            cnt     <= P_M1;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= P_M1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RECEIVER_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        PARITY: begin
`ifdef UART_RECEIVER_PARITY_EN
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            par_bit <= rx_s;
            cnt     <= P_M1;
            state   <= STOP;
          end
`else
          state <= IDLE;
`endif
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!rx_s) begin
            // A bad stop bit dominates any parity failure.
            framing_error_r <= 1'b1;
            state           <= WAIT_HIGH;
          end
`ifdef UART_RECEIVER_PARITY_EN
          else if (^{shreg, par_bit}) begin
            parity_error_r <= 1'b1;
            state          <= IDLE;
          end
`endif
          else begin
            byte_data_r  <= shreg;
            byte_valid_r <= 1'b1;
            state        <= IDLE;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.byte_data     = byte_data_r;
  assign bus.byte_valid    = byte_valid_r;
  assign bus.framing_error = framing_error_r;
`ifdef UART_RECEIVER_PARITY_EN
  assign bus.parity_error  = parity_error_r;
`else
  assign bus.parity_error  = 1'b0;
`endif

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter clk_mhz, default 50: clock frequency in MHz.
REQ-002 Parameter baud_rate, default 115200: serial bit rate in bits/s.
REQ-003 Port clk, input, 1: single clock, all state on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port uart_rx, input, 1: serial line, idle high, asynchronous to clk.
REQ-006 Port byte_data, output, 8: last correctly framed byte received.
REQ-007 Port byte_valid, output, 1: one-cycle pulse when byte_data is updated.
REQ-008 Port framing_error, output, 1: one-cycle pulse when the stop bit is sampled low.
REQ-009 Port parity_error, output, 1: one-cycle pulse when the parity check fails (see Configuration).

Function
REQ-010 The block SHALL pass uart_rx through a 2-flop synchronizer; all logic uses only the synchronized value rx_s.
REQ-011 The bit period SHALL be P = (clk_mhz * 1000000) / baud_rate with integer truncation (434 at the defaults); the half period SHALL be P/2, truncated (217).
REQ-012 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, an optional parity bit, and 1 stop bit (1).
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
- IDLE->START when rx_s is low.
- START: wait P/2 cycles, then sample. Low -> DATA. High -> IDLE (glitch rejected, no output).
- DATA: sample every P cycles, 8 samples, shift into the byte LSB first. After the 8th sample -> PARITY if enabled, else STOP.
- PARITY: sample once after P cycles -> STOP.
- STOP: sample after P cycles.
  - Sample 1 and no parity error: load byte_data, pulse byte_valid, go to IDLE.
  - Sample 0: pulse framing_error, leave byte_data unchanged, go to WAIT_HIGH.
- WAIT_HIGH->IDLE when rx_s is high (break condition held indefinitely without re-triggering).
REQ-014 byte_valid, framing_error and parity_error SHALL be high for exactly one cycle per frame and SHALL be mutually exclusive.
REQ-015 On a stop bit sampled 0 with a parity failure, only framing_error SHALL pulse.
REQ-016 byte_data SHALL hold its value between byte_valid pulses.
REQ-017 Latency: byte_valid SHALL rise between 9.5*P+2 and 9.5*P+4 cycles after the start-bit falling edge at the pin (10.5*P with parity).
REQ-018 A new start bit arriving immediately after a valid stop-bit sample SHALL be received; back-to-back frames with zero idle time SHALL not be lost.
REQ-019 The bit-period counter width SHALL be $clog2(P+1); the bit index SHALL be 3 bits and SHALL not wrap mid-frame.

Reset
REQ-020 While rst is high: state = IDLE, counters = 0, synchronizer flops = 1, byte_data = 8'h00, byte_valid/framing_error/parity_error = 0.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no pulse.
REQ-022 After reset release, reception SHALL restart only on a new falling edge seen from IDLE.

Configuration
REQ-023 Macro UART_RECEIVER_PARITY_EN defined: one even-parity bit is expected after the data bits. If the XOR of the 8 data bits and the parity bit is 1 with a good stop bit, parity_error SHALL pulse instead of byte_valid, and byte_data SHALL be unchanged.
REQ-024 Macro undefined: the PARITY state is unreachable, the frame is 10 bits, and parity_error SHALL be tied 0.

Verification (clk_mhz=50, baud_rate=115200, P=434)
REQ-025 Send frame 0x55 -> single byte_valid pulse, byte_data=8'h55, no error pulses.
REQ-026 Drive uart_rx low for 100 cycles then high -> no pulse on any output; the next frame 0xA3 is received as 8'hA3.
REQ-027 Send 0x3C with the stop bit driven 0, then hold high -> one framing_error pulse, byte_data keeps its prior value, and the next frame 0x01 is received correctly.
REQ-028 Send 0x00 then 0xFF with zero idle gap -> two byte_valid pulses, 10*P ±2 cycles apart, with values 8'h00 then 8'hFF.
REQ-029 Assert rst during data bit 4 of a frame, release, send 0x7E -> no pulse for the aborted frame, then byte_valid with 8'h7E.
REQ-030 With UART_RECEIVER_PARITY_EN: send 0x07 with parity bit 1 -> byte_valid with 8'h07; send 0x07 with parity bit 0 -> parity_error pulse only.
